// File: rtl/mult_seq_pkg.sv
// Shared types and widths for the multiplier job sequencer.
package mult_seq_pkg;
  localparam int OPW = 4;
  localparam int PW  = 8;

  typedef enum logic [2:0] {IDLE, START, ARM, RUN, HOLD} state_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } op_pair_t;
endpackage

// File: rtl/mult_seq_driver_if.sv
// Job, multiplier and result handshakes of the sequencer; slave = sequencer side.
interface mult_seq_driver_if;
  import mult_seq_pkg::*;
  logic           in_valid, in_ready;
  logic [OPW-1:0] in_a, in_b;
  logic           mul_start, mul_ready;
  logic [OPW-1:0] mul_a, mul_b;
  logic [PW-1:0]  mul_p;
  logic           out_valid, out_ready;
  logic [OPW-1:0] out_a, out_b;
  logic [PW-1:0]  out_p;
  logic           busy, err_timeout;

  modport slave (
    input  in_valid, in_a, in_b, mul_ready, mul_p, out_ready,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_a, out_b, out_p,
           busy, err_timeout
  );
  modport master (
    output in_valid, in_a, in_b, mul_ready, mul_p, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_a, out_b, out_p,
           busy, err_timeout
  );
endinterface

// File: rtl/mult_seq_driver_op_fifo.sv
// Operand-pair FIFO with wrap-bit pointers; no push/pop bypass.
module op_fifo
  import mult_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  op_pair_t din,
  output op_pair_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr, rd_ptr;
  op_pair_t    mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/mult_seq_driver.sv
// Feeds queued operand pairs to a 4x4 shift-add multiplier, one START per job,
// and holds each {a,b,p} result on a valid/ready output.
module mult_seq_driver
  import mult_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic              CK,
  input logic              RST,
  mult_seq_driver_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = 1;

  state_t         state, state_nxt;
  logic [TW-1:0]  timer, timer_nxt;
  logic           pop, capture, release_r, abandon, full, empty;
  op_pair_t       head, din;
  logic [OPW-1:0] mul_a_r, mul_b_r, out_a_r, out_b_r;
  logic [PW-1:0]  out_p_r;
  logic           out_valid_r, err_r;

  assign din = '{a: bus.in_a, b: bus.in_b};

  op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CK),
    .rst   (RST),
    .push  (bus.in_valid),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // A job gets at most TIMEOUT cycles across ARM+RUN; a READY seen in RUN on
  // the last of them still wins over abandoning.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pop       = 1'b0;
    capture   = 1'b0;
    release_r = 1'b0;
    abandon   = 1'b0;
    unique case (state)
      IDLE:  if (!empty) begin
               pop       = 1'b1;
               state_nxt = START;
             end
      START: begin
               timer_nxt = '0;
               state_nxt = ARM;
             end
      ARM:   if (timer == TMO_LAST) begin
               abandon   = 1'b1;
               state_nxt = IDLE;
             end else begin
               timer_nxt = timer + TMR_ONE;
               if (!bus.mul_ready) state_nxt = RUN;
             end
      RUN:   if (bus.mul_ready) begin
               capture   = 1'b1;
               state_nxt = HOLD;
             end else if (timer == TMO_LAST) begin
               abandon   = 1'b1;
               state_nxt = IDLE;
             end else begin
               timer_nxt = timer + TMR_ONE;
             end
      HOLD:  if (bus.out_ready) begin
               release_r = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state       <= IDLE;
      timer       <= '0;
      mul_a_r     <= '0;
      mul_b_r     <= '0;
      out_a_r     <= '0;
      out_b_r     <= '0;
      out_p_r     <= '0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (pop) begin
        mul_a_r <= head.a;
        mul_b_r <= head.b;
      end
      if (capture) begin
        out_a_r     <= mul_a_r;
        out_b_r     <= mul_b_r;
        out_p_r     <= bus.mul_p;
        out_valid_r <= 1'b1;
      end
      if (release_r) out_valid_r <= 1'b0;
      if (abandon)   err_r       <= 1'b1;
    end
  end

  assign bus.in_ready    = !full;
  assign bus.mul_start   = (state == START);
  assign bus.mul_a       = mul_a_r;
  assign bus.mul_b       = mul_b_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_a       = out_a_r;
  assign bus.out_b       = out_b_r;
  assign bus.out_p       = out_p_r;
  assign bus.busy        = (state != IDLE) || !empty;
  assign bus.err_timeout = err_r;
endmodule

// File: tb/tb_mult_seq_driver.sv
// Directed bench for mult_seq_driver with a behavioural 4x4 multiplier model.
module tb_mult_seq_driver;
  logic CK = 1'b0;
  logic RST = 1'b1;
  always #5 CK = ~CK;

  mult_seq_driver_if bus();

  mult_seq_driver #(.DEPTH(4), .TIMEOUT(15)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus)
  );

  // multiplier model: READY drops the cycle after START, rises 5 cycles later
  logic       mready = 1'b1;
  logic [7:0] mp = 8'd0;
  int         mcnt = 0;
  int         mode = 0;          // 0 model, 1 READY tied low, 2 manual
  logic       man_ready = 1'b0;
  logic [7:0] man_p = 8'd0;

  always @(posedge CK) begin
    if (bus.mul_start) begin
      mready <= 1'b0;
      mcnt   <= 5;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mready <= 1'b1;
        mp     <= {4'b0, bus.mul_a} * {4'b0, bus.mul_b};
      end
    end
  end

  assign bus.mul_ready = (mode == 0) ? mready : ((mode == 1) ? 1'b0 : man_ready);
  assign bus.mul_p     = (mode == 2) ? man_p : mp;

  int nstart = 0;
  always @(posedge CK) if (bus.mul_start) nstart <= nstart + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge CK);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int maxc);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < maxc) begin
      @(negedge CK);
      n++;
    end
    check(name, 32'(bus.out_valid), 1);
  endtask

  task automatic wait_start(input string name, input int maxc);
    int n = 0;
    while (bus.mul_start !== 1'b1 && n < maxc) begin
      @(negedge CK);
      n++;
    end
    check(name, 32'(bus.mul_start), 1);
  endtask

  task automatic drain_one();
    bus.out_ready = 1'b1;
    @(negedge CK);
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vt[5];
  vec_t fq[5];

  initial begin
    int s0, bad, idx, extra;
    vt[0] = '{a: 4'd15, b: 4'd15, p: 8'd225};
    vt[1] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
    vt[2] = '{a: 4'd7,  b: 4'd1,  p: 8'd7};
    vt[3] = '{a: 4'd12, b: 4'd10, p: 8'd120};
    vt[4] = '{a: 4'd9,  b: 4'd13, p: 8'd117};
    fq[0] = '{a: 4'd1,  b: 4'd2,  p: 8'd2};
    fq[1] = '{a: 4'd2,  b: 4'd3,  p: 8'd6};
    fq[2] = '{a: 4'd4,  b: 4'd4,  p: 8'd16};
    fq[3] = '{a: 4'd5,  b: 4'd6,  p: 8'd30};
    fq[4] = '{a: 4'd11, b: 4'd3,  p: 8'd33};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // reset
    repeat (2) @(negedge CK);
    check("rst_in_ready",  32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_mul_start", 32'(bus.mul_start), 0);
    check("rst_busy",      32'(bus.busy), 0);
    check("rst_err",       32'(bus.err_timeout), 0);
    check("rst_out_p",     32'(bus.out_p), 0);
    RST = 1'b0;
    @(negedge CK);

    // single job with exact latency: push t, pop t+1, start t+2, valid start+7
    s0 = nstart;
    push(4'd3, 4'd5);
    check("lat_busy",       32'(bus.busy), 1);
    check("lat_no_start",   32'(bus.mul_start), 0);
    @(negedge CK);
    check("lat_start",      32'(bus.mul_start), 1);
    check("lat_mul_a",      32'(bus.mul_a), 3);
    check("lat_mul_b",      32'(bus.mul_b), 5);
    @(negedge CK);
    check("lat_start_once", 32'(bus.mul_start), 0);
    repeat (5) @(negedge CK);
    check("lat_valid_early", 32'(bus.out_valid), 0);
    @(negedge CK);
    check("lat_valid",      32'(bus.out_valid), 1);
    check("lat_out_p",      32'(bus.out_p), 15);
    check("lat_out_a",      32'(bus.out_a), 3);
    check("lat_out_b",      32'(bus.out_b), 5);
    check("lat_nstart",     32'(nstart - s0), 1);
    drain_one();
    check("lat_release",    32'(bus.out_valid), 0);

    // table of single jobs
    for (int i = 0; i < 5; i++) begin
      s0 = nstart;
      push(vt[i].a, vt[i].b);
      wait_valid("vec_valid", 30);
      check("vec_out_a", 32'(bus.out_a), 32'(vt[i].a));
      check("vec_out_b", 32'(bus.out_b), 32'(vt[i].b));
      check("vec_out_p", 32'(bus.out_p), 32'(vt[i].p));
      check("vec_nstart", 32'(nstart - s0), 1);
      drain_one();
      check("vec_release", 32'(bus.out_valid), 0);
    end

    // FIFO full: first entry pops, next four fill it
    for (int i = 0; i < 5; i++) push(fq[i].a, fq[i].b);
    check("full_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b1;
    bus.in_a = 4'd9;
    bus.in_b = 4'd9;
    @(negedge CK);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    idx = 0;
    bad = 0;
    for (int n = 0; n < 200 && idx < 5; n++) begin
      if (bus.out_valid === 1'b1) begin
        if (bus.out_a !== fq[idx].a || bus.out_b !== fq[idx].b || bus.out_p !== fq[idx].p) begin
          bad++;
          $display("FAIL full_order: idx %0d got %0d*%0d=%0d expected %0d*%0d=%0d", idx,
                   bus.out_a, bus.out_b, bus.out_p, fq[idx].a, fq[idx].b, fq[idx].p);
        end
        idx++;
      end
      @(negedge CK);
    end
    check("full_count", 32'(idx), 5);
    check("full_order_bad", 32'(bad), 0);
    extra = 0;
    for (int n = 0; n < 20; n++) begin
      if (bus.out_valid === 1'b1) extra++;
      @(negedge CK);
    end
    bus.out_ready = 1'b0;
    check("full_rejected_push", 32'(extra), 0);
    check("full_idle", 32'(bus.busy), 0);

    // backpressure in HOLD with a job waiting behind it
    push(4'd6, 4'd7);
    wait_valid("bp_valid", 30);
    s0 = nstart;
    push(4'd8, 4'd8);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.out_p !== 8'd42 || bus.out_a !== 4'd6 || bus.out_b !== 4'd7 ||
          bus.out_valid !== 1'b1) bad++;
      @(negedge CK);
    end
    check("bp_stable", 32'(bad), 0);
    check("bp_no_start", 32'(nstart - s0), 0);
    check("bp_mul_a_held", 32'(bus.mul_a), 6);
    check("bp_busy", 32'(bus.busy), 1);
    drain_one();
    wait_valid("bp_next_valid", 30);
    check("bp_next_p", 32'(bus.out_p), 64);
    drain_one();

    // timeout with READY tied low
    mode = 1;
    push(4'd2, 4'd2);
    wait_start("tmo_start", 10);
    repeat (15) @(negedge CK);
    check("tmo_not_yet", 32'(bus.err_timeout), 0);
    check("tmo_still_busy", 32'(bus.busy), 1);
    @(negedge CK);
    check("tmo_err", 32'(bus.err_timeout), 1);
    check("tmo_no_valid", 32'(bus.out_valid), 0);
    check("tmo_idle", 32'(bus.busy), 0);
    mode = 0;
    push(4'd3, 4'd4);
    wait_valid("tmo_next_valid", 30);
    check("tmo_next_p", 32'(bus.out_p), 12);
    check("tmo_err_sticky", 32'(bus.err_timeout), 1);
    drain_one();

    // stale READY: ARM must wait for READY low before RUN can capture
    mode = 2;
    man_ready = 1'b1;
    man_p = 8'd99;
    push(4'd5, 4'd5);
    wait_start("stale_start", 10);
    bad = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge CK);
      if (bus.out_valid !== 1'b0) bad++;
    end
    man_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge CK);
      if (bus.out_valid !== 1'b0) bad++;
    end
    check("stale_no_capture", 32'(bad), 0);
    man_ready = 1'b1;
    man_p = 8'd25;
    @(negedge CK);
    check("stale_valid", 32'(bus.out_valid), 1);
    check("stale_p", 32'(bus.out_p), 25);
    check("stale_a", 32'(bus.out_a), 5);
    drain_one();

    // reset in the middle of RUN with another job queued
    man_ready = 1'b0;
    push(4'd7, 4'd7);
    push(4'd1, 4'd1);
    wait_start("rr_start", 10);
    repeat (2) @(negedge CK);
    check("rr_busy_before", 32'(bus.busy), 1);
    RST = 1'b1;
    @(negedge CK);
    check("rr_out_valid", 32'(bus.out_valid), 0);
    check("rr_busy", 32'(bus.busy), 0);
    check("rr_in_ready", 32'(bus.in_ready), 1);
    check("rr_mul_start", 32'(bus.mul_start), 0);
    check("rr_err_clr", 32'(bus.err_timeout), 0);
    check("rr_mul_a", 32'(bus.mul_a), 0);
    RST = 1'b0;
    mode = 0;
    @(negedge CK);
    s0 = nstart;
    push(4'd9, 4'd13);
    wait_valid("rr_next_valid", 30);
    check("rr_next_p", 32'(bus.out_p), 117);
    check("rr_next_nstart", 32'(nstart - s0), 1);
    drain_one();
    repeat (10) @(negedge CK);
    check("rr_flushed", 32'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
